// File: rtl/layer_out_serializer.sv
// Frame FIFO + word serializer onto AXI-Stream or AXI-Lite word pop; optional argmax via SERIALIZER_ARGMAX_EN.
// Latency: frame strobed at edge N into an empty FIFO shows tvalid after edge N+1; gapless between frames.
// Backpressure: words hold while tready/axi_rd_en is low; a frame arriving on a full FIFO with no pop is dropped (sticky overflow).
module layer_out_serializer #(
  parameter int NUM_OUT     = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_DEPTH = 4,
  localparam int IDX_W      = $clog2(NUM_OUT),
  localparam int CNT_W      = $clog2(FRAME_DEPTH) + 1
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic                             soft_reset,
  input  logic [NUM_OUT*DATA_WIDTH-1:0]    i_data,
  input  logic                             i_valid,
  input  logic                             cfg_rd_mode,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  input  logic                             axi_rd_en,
  output logic [DATA_WIDTH-1:0]            axi_rd_data,
  output logic [CNT_W-1:0]                 frame_count,
  output logic                             overflow,
  output logic                             intr,
  output logic [IDX_W-1:0]                 argmax_idx,
  output logic                             argmax_valid
);

  localparam int PTR_W   = $clog2(FRAME_DEPTH);
  localparam int FRAME_W = NUM_OUT * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [FRAME_W-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0]       word_cnt_q, word_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   intr_q, intr_d;
  logic [FRAME_W-1:0]     fifo_mem_q [FRAME_DEPTH];

  logic fifo_empty, fifo_full, in_send, word_hs, last_hs, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FRAME_DEPTH));
  assign in_send    = (state_q == ST_SEND);
  assign word_hs    = in_send & (mode_q ? axi_rd_en : m_axis_tready);
  assign last_hs    = word_hs & (word_cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    intr_d     = 1'b0;
    pop        = 1'b0;
    if (word_hs) begin
      shift_d    = shift_q >> DATA_WIDTH;
      word_cnt_d = word_cnt_q + IDX_W'(1);
    end
    if (last_hs) begin
      intr_d  = 1'b1;
      state_d = ST_IDLE;
    end
    // Reload on the last-word handshake keeps back-to-back frames bubble-free.
    if (!fifo_empty && (!in_send || last_hs)) begin
      pop        = 1'b1;
      shift_d    = fifo_mem_q[rd_ptr_q];
      word_cnt_d = '0;
      mode_d     = cfg_rd_mode;
      state_d    = ST_SEND;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    push = i_valid & (!fifo_full | pop);
    if (i_valid && fifo_full && !pop) overflow_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (soft_reset) begin
      state_d    = ST_IDLE;
      mode_d     = 1'b0;
      shift_d    = '0;
      word_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      intr_d     = 1'b0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      intr_q     <= intr_d;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= i_data;
  end

  assign m_axis_tdata  = in_send ? shift_q[DATA_WIDTH-1:0] : '0;
  assign axi_rd_data   = in_send ? shift_q[DATA_WIDTH-1:0] : '0;
  assign m_axis_tvalid = in_send & ~mode_q;
  assign m_axis_tlast  = in_send & (word_cnt_q == LAST_IDX);
  assign frame_count   = count_q;
  assign overflow      = overflow_q;
  assign intr          = intr_q;

`ifdef SERIALIZER_ARGMAX_EN
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]      max_idx_q, max_idx_d, argmax_idx_q, argmax_idx_d;
  logic                  argmax_valid_q, argmax_valid_d;

  // Strict greater-than keeps the lower index on ties.
  always_comb begin
    max_d          = max_q;
    max_idx_d      = max_idx_q;
    argmax_idx_d   = argmax_idx_q;
    argmax_valid_d = 1'b0;
    if (word_hs && ((word_cnt_q == '0) ||
                    ($signed(shift_q[DATA_WIDTH-1:0]) > $signed(max_q)))) begin
      max_d     = shift_q[DATA_WIDTH-1:0];
      max_idx_d = word_cnt_q;
    end
    if (last_hs) begin
      argmax_idx_d   = max_idx_d;
      argmax_valid_d = 1'b1;
    end
    if (soft_reset) begin
      max_d          = '0;
      max_idx_d      = '0;
      argmax_idx_d   = '0;
      argmax_valid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      max_q          <= '0;
      max_idx_q      <= '0;
      argmax_idx_q   <= '0;
      argmax_valid_q <= 1'b0;
    end else begin
      max_q          <= max_d;
      max_idx_q      <= max_idx_d;
      argmax_idx_q   <= argmax_idx_d;
      argmax_valid_q <= argmax_valid_d;
    end
  end

  assign argmax_idx   = argmax_idx_q;
  assign argmax_valid = argmax_valid_q;
`else
  assign argmax_idx   = '0;
  assign argmax_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Scoreboard bench for layer_out_serializer (NUM_OUT=4, DATA_WIDTH=16, FRAME_DEPTH=4).
module tb_layer_out_serializer;
  localparam int NUM_OUT = 4;
  localparam int DW      = 16;
  localparam int FD      = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 3;
`ifdef SERIALIZER_ARGMAX_EN
  localparam bit AM = 1'b1;
`else
  localparam bit AM = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   soft_reset = 1'b0;
  logic [NUM_OUT*DW-1:0]  i_data = '0;
  logic                   i_valid = 1'b0;
  logic                   cfg_rd_mode = 1'b0;
  logic                   tready = 1'b0;
  logic                   axi_rd_en = 1'b0;
  logic [DW-1:0]          tdata, rd_data;
  logic                   tvalid, tlast, overflow, intr, argmax_valid;
  logic [CNT_W-1:0]       frame_count;
  logic [IDX_W-1:0]       argmax_idx;

  layer_out_serializer #(.NUM_OUT(NUM_OUT), .DATA_WIDTH(DW), .FRAME_DEPTH(FD)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .i_data(i_data), .i_valid(i_valid), .cfg_rd_mode(cfg_rd_mode),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .axi_rd_en(axi_rd_en), .axi_rd_data(rd_data), .frame_count(frame_count),
    .overflow(overflow), .intr(intr), .argmax_idx(argmax_idx), .argmax_valid(argmax_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  int xfer_cnt = 0;
  int intr_cnt = 0;
  int exp_argmax = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: every visible word must equal the scoreboard head and stay there until accepted.
  always @(negedge clk) begin
    if (tvalid) begin
      if (exp_q.size() == 0) chk("unexpected_tvalid", 32'(tvalid), 32'd0);
      else begin
        chk("tdata", 32'(tdata), 32'(exp_q[0][15:0]));
        chk("tlast", 32'(tlast), 32'(exp_q[0][16]));
        if (tready) begin
          void'(exp_q.pop_front());
          xfer_cnt++;
        end
      end
    end
    if (intr) begin
      intr_cnt++;
      chk("argmax_valid", 32'(argmax_valid), 32'(AM));
      chk("argmax_idx", 32'(argmax_idx), AM ? 32'(exp_argmax) : 32'd0);
    end else begin
      chk("argmax_valid_idle", 32'(argmax_valid), 32'd0);
    end
  end

  task automatic push_frame(input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input bit acc);
    i_data  = {w3, w2, w1, w0};
    i_valid = 1'b1;
    if (acc) begin
      exp_q.push_back({1'b0, w0});
      exp_q.push_back({1'b0, w1});
      exp_q.push_back({1'b0, w2});
      exp_q.push_back({1'b1, w3});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, ic;
    logic [15:0] rd_exp [4];
    rd_exp[0] = 16'd5; rd_exp[1] = 16'd7; rd_exp[2] = 16'hFFFE; rd_exp[3] = 16'd9;

    #12;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_tlast", 32'(tlast), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_intr", 32'(intr), 0);
    chk("rst_argmax_idx", 32'(argmax_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single frame, stream mode: latency, consecutive words, intr pulse.
    tready = 1'b1; exp_argmax = 3; ic = intr_cnt;
    push_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    chk("t1_tvalid_edge_n", 32'(tvalid), 0);
    @(posedge clk); #1;
    chk("t1_tvalid_edge_n1", 32'(tvalid), 1);
    chk("t1_first_word", 32'(tdata), 32'h0001);
    repeat (4) begin @(posedge clk); #1; end
    chk("t1_consecutive", 32'(exp_q.size()), 0);
    chk("t1_intr", 32'(intr), 1);
    @(posedge clk); #1;
    chk("t1_intr_pulse", 32'(intr), 0);
    chk("t1_intr_count", 32'(intr_cnt - ic), 1);

    // Backpressure: tready pattern 1,0,0,1.
    base = xfer_cnt;
    push_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      tready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
    end
    chk("t2_drained", 32'(exp_q.size()), 0);
    chk("t2_xfers", 32'(xfer_cnt - base), 4);
    tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t2_xfers_no_dup", 32'(xfer_cnt - base), 4);

    // Overflow: 6 frames into a stalled stream, then gapless drain.
    tready = 1'b0; ic = intr_cnt; exp_argmax = 3;
    for (int f = 0; f < 6; f++)
      push_frame(16'(16'h100 + f*16), 16'(16'h101 + f*16), 16'(16'h102 + f*16), 16'(16'h103 + f*16), f < 5);
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_frame_count", 32'(frame_count), 4);
    chk("t3_overflow", 32'(overflow), 1);
    tready = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("t3_gapless_20", 32'(exp_q.size()), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("t3_intr_count", 32'(intr_cnt - ic), 5);
    chk("t3_frame_count_empty", 32'(frame_count), 0);
    chk("t3_overflow_sticky", 32'(overflow), 1);

    // Read mode: word pops via axi_rd_en; stream stays silent.
    cfg_rd_mode = 1'b1; exp_argmax = 3;
    push_frame(16'd5, 16'd7, 16'hFFFE, 16'd9, 1'b0);
    @(posedge clk); #1;
    chk("t4_tvalid", 32'(tvalid), 0);
    chk("t4_rd0", 32'(rd_data), 32'(rd_exp[0]));
    for (int k = 1; k < 4; k++) begin
      axi_rd_en = 1'b1;
      @(posedge clk); #1;
      axi_rd_en = 1'b0;
      chk("t4_rd_word", 32'(rd_data), 32'(rd_exp[k]));
      @(posedge clk); #1;
      chk("t4_rd_hold", 32'(rd_data), 32'(rd_exp[k]));
    end
    axi_rd_en = 1'b1;
    @(posedge clk); #1;
    axi_rd_en = 1'b0;
    chk("t4_intr", 32'(intr), 1);
    chk("t4_tvalid_end", 32'(tvalid), 0);
    cfg_rd_mode = 1'b0;
    @(posedge clk); #1;

    // Argmax with a tie at the max.
    exp_argmax = 1;
    push_frame(16'hFFFD, 16'd8, 16'd8, 16'd1, 1'b1);
    wait_drain(20);
    repeat (2) begin @(posedge clk); #1; end

    // Asynchronous reset mid-frame, then a clean frame.
    push_frame(16'h11, 16'h12, 16'h13, 16'h14, 1'b1);
    push_frame(16'h21, 16'h22, 16'h23, 16'h24, 1'b1);
    @(posedge clk); #1;
    chk("t6_pre_overflow", 32'(overflow), 1);
    chk("t6_pre_word1", 32'(tdata), 32'h12);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_tvalid_now", 32'(tvalid), 0);
    chk("t6_frame_count", 32'(frame_count), 0);
    chk("t6_overflow", 32'(overflow), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ic = intr_cnt; exp_argmax = 1;
    push_frame(16'd2, 16'd9, 16'd1, 16'd0, 1'b1);
    wait_drain(20);
    repeat (2) begin @(posedge clk); #1; end
    chk("t6_post_intr", 32'(intr_cnt - ic), 1);

    // Soft reset with one frame sending and one buffered.
    tready = 1'b0;
    push_frame(16'h31, 16'h32, 16'h33, 16'h34, 1'b1);
    push_frame(16'h41, 16'h42, 16'h43, 16'h44, 1'b1);
    chk("t7_frame_count", 32'(frame_count), 1);
    chk("t7_tvalid", 32'(tvalid), 1);
    soft_reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    soft_reset = 1'b0;
    chk("t7_tvalid_cleared", 32'(tvalid), 0);
    chk("t7_count_cleared", 32'(frame_count), 0);
    tready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("t7_stays_idle", 32'(tvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
